// File: rtl/cond_flag_unit_pkg.sv
// Shared definitions for the NZCV status / condition evaluation block:
// ARM condition-code encodings and status-register bit positions.
// Used by the top, the condition checker, and the ALU / ID decode.
package cond_flag_unit_pkg;

    // ARM condition field [31:28]
    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    // Status register bit indices on the 4-bit {Z,C,N,V} bus
    localparam int SR_Z = 3;
    localparam int SR_C = 2;
    localparam int SR_N = 1;
    localparam int SR_V = 0;

endpackage

// File: rtl/cond_flag_unit_cond_check.sv
// Purpose: evaluate an ARM condition code against a {Z,C,N,V} flag vector.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no handshake.
// Ports: cond  - 4-bit condition field
//        flags - {Z,C,N,V} status to test
//        pass  - 1 when the condition holds
module cond_flag_unit_cond_check
    import cond_flag_unit_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic z, c, n, v;

    assign z = flags[SR_Z];
    assign c = flags[SR_C];
    assign n = flags[SR_N];
    assign v = flags[SR_V];

    always_comb begin
        pass = 1'b0;
        unique case (cond_e'(cond))
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c & !z;
            COND_LS: pass = !c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_flag_unit.sv
// Purpose: NZCV status register, in-flight flag-writer tracking, and condition-gated issue for ID.
// Latency: zero-cycle issue decision; EXE status write visible to ID in the same cycle (forwarded).
// Backpressure: id_ready drops while flags are still in flight for a conditional op or the writer budget is full.
// Ports: clk, rst_n (async active-low); flush squashes in-flight writers younger than EXE;
//        id_valid/id_cond/id_s/id_ready/id_cond_pass form the ID issue handshake;
//        exe_wr/exe_sr carry the EXE status write; sr_q, alu_cin, pending_cnt, err are status outputs.
module cond_flag_unit
    import cond_flag_unit_pkg::*;
#(
    parameter int MAX_PENDING = 3,
    parameter int CNT_W       = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [3:0]       id_cond,
    input  logic             id_s,
    output logic             id_ready,
    output logic             id_cond_pass,
    input  logic             exe_wr,
    input  logic [3:0]       exe_sr,
    output logic [3:0]       sr_q,
    output logic             alu_cin,
    output logic [CNT_W-1:0] pending_cnt,
    output logic             err
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PENDING);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    logic       cnt_zero;
    logic       wr_ok;
    logic [3:0] eff_flags;
    logic       flags_ok;
    logic       cap_ok;
    logic       fire;
    logic       inc;

    assign cnt_zero = (pending_cnt == '0);

    // An EXE write only counts when someone is actually waiting on it;
    // a stray write is a protocol error and must not disturb the status.
    assign wr_ok = exe_wr & !cnt_zero;

    // Forward the EXE write so a conditional op can issue in the cycle its flags land.
    assign eff_flags = wr_ok ? exe_sr : sr_q;

    // Only the last outstanding writer may be retiring for the flags to be final.
    assign flags_ok = (id_cond == COND_AL) | cnt_zero | ((pending_cnt == ONE_CNT) & exe_wr);
    assign cap_ok   = !id_s | (pending_cnt < MAX_CNT) | ((pending_cnt == MAX_CNT) & exe_wr);
    assign id_ready = flags_ok & cap_ok;

    assign fire = id_valid & id_ready & !flush;
    assign inc  = fire & id_s;

    cond_flag_unit_cond_check u_cond_check (
        .cond  (id_cond),
        .flags (eff_flags),
        .pass  (id_cond_pass)
    );

    assign alu_cin = sr_q[SR_C];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_cnt <= '0;
        end else if (flush) begin
            // Every counted writer younger than EXE is squashed; the EXE one retires now.
            pending_cnt <= '0;
        end else if (inc && !wr_ok) begin
            pending_cnt <= pending_cnt + ONE_CNT;
        end else if (wr_ok && !inc) begin
            pending_cnt <= pending_cnt - ONE_CNT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= 4'b0000;
        end else if (wr_ok) begin
            sr_q <= exe_sr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (exe_wr && cnt_zero) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cond_flag_unit.sv
module tb_cond_flag_unit;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       id_valid;
    logic [3:0] id_cond;
    logic       id_s;
    logic       id_ready;
    logic       id_cond_pass;
    logic       exe_wr;
    logic [3:0] exe_sr;
    logic [3:0] sr_q;
    logic       alu_cin;
    logic [1:0] pending_cnt;
    logic       err;

    int errors = 0;
    int checks = 0;

    cond_flag_unit #(.MAX_PENDING(3), .CNT_W(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .id_valid     (id_valid),
        .id_cond      (id_cond),
        .id_s         (id_s),
        .id_ready     (id_ready),
        .id_cond_pass (id_cond_pass),
        .exe_wr       (exe_wr),
        .exe_sr       (exe_sr),
        .sr_q         (sr_q),
        .alu_cin      (alu_cin),
        .pending_cnt  (pending_cnt),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference condition table: base test on cond[3:1], cond[0] inverts it.
    function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
        logic fz, fc, fn, fv, base;
        fz = f[3]; fc = f[2]; fn = f[1]; fv = f[0];
        case (c[3:1])
            3'd0: base = fz;
            3'd1: base = fc;
            3'd2: base = fn;
            3'd3: base = fv;
            3'd4: base = fc && !fz;
            3'd5: base = (fn == fv);
            3'd6: base = !fz && (fn == fv);
            default: base = 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    task automatic drive(input logic v, input logic [3:0] c, input logic s,
                         input logic w, input logic [3:0] sr, input logic f);
        id_valid = v;
        id_cond  = c;
        id_s     = s;
        exe_wr   = w;
        exe_sr   = sr;
        flush    = f;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drive(1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0);
        #1;
        checks++; if (sr_q !== 4'b0000) begin errors++; $display("FAIL reset_sr got=%b exp=0000", sr_q); end
        checks++; if (pending_cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", pending_cnt); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (alu_cin !== 1'b0) begin errors++; $display("FAIL reset_cin got=%b exp=0", alu_cin); end
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", id_ready); end
        checks++; if (id_cond_pass !== 1'b0) begin errors++; $display("FAIL reset_eq got=%b exp=0", id_cond_pass); end
        id_cond = 4'b0001; #1;
        checks++; if (id_cond_pass !== 1'b1) begin errors++; $display("FAIL reset_ne got=%b exp=1", id_cond_pass); end
        id_cond = 4'b1111; #1;
        checks++; if (id_cond_pass !== 1'b0) begin errors++; $display("FAIL reset_nv got=%b exp=0", id_cond_pass); end
        drive(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_stall;
        @(negedge clk);
        drive(1'b1, 4'b1110, 1'b1, 1'b0, 4'b0000, 1'b0);  // S=1 ADD, AL
        @(negedge clk);
        checks++; if (pending_cnt !== 2'd1) begin errors++; $display("FAIL stall_cnt1 got=%0d exp=1", pending_cnt); end
        drive(1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0);  // EQ waits
        #1;
        checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got=%b exp=0", id_ready); end
        @(negedge clk);
        checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL stall_hold got=%b exp=0", id_ready); end
        exe_wr = 1'b1; exe_sr = 4'b1000;
        #1;
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL stall_fwd_ready got=%b exp=1", id_ready); end
        checks++; if (id_cond_pass !== 1'b1) begin errors++; $display("FAIL stall_fwd_pass got=%b exp=1", id_cond_pass); end
        @(negedge clk);
        drive(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0);
        #1;
        checks++; if (sr_q !== 4'b1000) begin errors++; $display("FAIL stall_sr got=%b exp=1000", sr_q); end
        checks++; if (pending_cnt !== 2'd0) begin errors++; $display("FAIL stall_cnt0 got=%0d exp=0", pending_cnt); end
    endtask

    task automatic test_capacity;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b1, 4'b1110, 1'b1, 1'b0, 4'b0000, 1'b0);
        end
        @(negedge clk);
        checks++; if (pending_cnt !== 2'd3) begin errors++; $display("FAIL cap_cnt3 got=%0d exp=3", pending_cnt); end
        #1;
        checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL cap_full got=%b exp=0", id_ready); end
        exe_wr = 1'b1; exe_sr = 4'b0010;
        #1;
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL cap_wr_ready got=%b exp=1", id_ready); end
        @(negedge clk);
        drive(1'b0, 4'b1110, 1'b0, 1'b1, 4'b0011, 1'b0);  // retire one, no issue
        checks++; if (pending_cnt !== 2'd3) begin errors++; $display("FAIL cap_hold got=%0d exp=3", pending_cnt); end
        checks++; if (sr_q !== 4'b0010) begin errors++; $display("FAIL cap_sr got=%b exp=0010", sr_q); end
        @(negedge clk);
        drive(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0);
        checks++; if (pending_cnt !== 2'd2) begin errors++; $display("FAIL cap_cnt2 got=%0d exp=2", pending_cnt); end
    endtask

    task automatic test_flush;
        // pending_cnt is 2 here; a younger S=1 op is presented alongside the flush
        drive(1'b1, 4'b1110, 1'b1, 1'b1, 4'b0101, 1'b1);
        #1;
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got=%b exp=1", id_ready); end
        @(negedge clk);
        drive(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0);
        checks++; if (pending_cnt !== 2'd0) begin errors++; $display("FAIL flush_cnt got=%0d exp=0", pending_cnt); end
        checks++; if (sr_q !== 4'b0101) begin errors++; $display("FAIL flush_sr got=%b exp=0101", sr_q); end
        checks++; if (alu_cin !== 1'b1) begin errors++; $display("FAIL flush_cin got=%b exp=1", alu_cin); end
    endtask

    task automatic test_err;
        drive(1'b0, 4'b0000, 1'b0, 1'b1, 4'b1111, 1'b0);
        @(negedge clk);
        drive(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0);
        checks++; if (sr_q !== 4'b0101) begin errors++; $display("FAIL err_sr got=%b exp=0101", sr_q); end
        checks++; if (pending_cnt !== 2'd0) begin errors++; $display("FAIL err_cnt got=%0d exp=0", pending_cnt); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set got=%b exp=1", err); end
        @(negedge clk);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", err); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_rst got=%b exp=0", err); end
        checks++; if (sr_q !== 4'b0000) begin errors++; $display("FAIL err_rst_sr got=%b exp=0000", sr_q); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Full 16x16 table via the forward path: one writer in flight, each cycle
    // retires one and issues one S=1 op, so the count holds at 1.
    task automatic test_back_to_back;
        logic [3:0] prev_sr;
        logic       have_prev;
        @(negedge clk);
        drive(1'b1, 4'b1110, 1'b1, 1'b0, 4'b0000, 1'b0);
        have_prev = 1'b0;
        prev_sr   = 4'b0000;
        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 16; f++) begin
                @(negedge clk);
                if (have_prev) begin
                    checks++; if (sr_q !== prev_sr) begin errors++; $display("FAIL b2b_sr got=%b exp=%b", sr_q, prev_sr); end
                end
                checks++; if (pending_cnt !== 2'd1) begin errors++; $display("FAIL b2b_cnt got=%0d exp=1", pending_cnt); end
                drive(1'b1, 4'(c), 1'b1, 1'b1, 4'(f), 1'b0);
                #1;
                checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready c=%0d f=%0d got=%b exp=1", c, f, id_ready); end
                checks++;
                if (id_cond_pass !== cond_ref(4'(c), 4'(f))) begin
                    errors++;
                    $display("FAIL b2b_pass c=%b f=%b got=%b exp=%b", 4'(c), 4'(f), id_cond_pass, cond_ref(4'(c), 4'(f)));
                end
                prev_sr   = 4'(f);
                have_prev = 1'b1;
            end
        end
        @(negedge clk);
        drive(1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0);  // drain last writer
        @(negedge clk);
        drive(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0);
        checks++; if (pending_cnt !== 2'd0) begin errors++; $display("FAIL b2b_drain got=%0d exp=0", pending_cnt); end
    endtask

    task automatic test_random;
        int         m_cnt;
        logic [3:0] m_sr;
        logic       m_err;
        logic       v, s, w, f, exp_ready, exp_pass, wr_ok, fire;
        logic [3:0] c, sr, eff;
        @(negedge clk);
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        m_cnt = 0; m_sr = 4'b0000; m_err = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            checks++; if (int'(pending_cnt) != m_cnt) begin errors++; $display("FAIL rnd_cnt i=%0d got=%0d exp=%0d", i, pending_cnt, m_cnt); end
            checks++; if (sr_q !== m_sr) begin errors++; $display("FAIL rnd_sr i=%0d got=%b exp=%b", i, sr_q, m_sr); end
            checks++; if (alu_cin !== m_sr[2]) begin errors++; $display("FAIL rnd_cin i=%0d got=%b exp=%b", i, alu_cin, m_sr[2]); end
            checks++; if (err !== m_err) begin errors++; $display("FAIL rnd_err i=%0d got=%b exp=%b", i, err, m_err); end
            v  = 1'($urandom_range(0, 3) != 0);
            c  = ($urandom_range(0, 2) == 0) ? 4'b1110 : 4'($urandom_range(0, 15));
            s  = 1'($urandom_range(0, 1));
            w  = (m_cnt > 0) ? 1'($urandom_range(0, 1)) : 1'($urandom_range(0, 99) == 0);
            sr = 4'($urandom_range(0, 15));
            f  = 1'($urandom_range(0, 15) == 0);
            drive(v, c, s, w, sr, f);
            wr_ok     = w && (m_cnt != 0);
            eff       = wr_ok ? sr : m_sr;
            exp_ready = (c == 4'b1110 || m_cnt == 0 || (m_cnt == 1 && w)) &&
                        (!s || m_cnt < 3 || (m_cnt == 3 && w));
            exp_pass  = cond_ref(c, eff);
            #1;
            checks++; if (id_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready i=%0d got=%b exp=%b", i, id_ready, exp_ready); end
            if (exp_ready) begin
                checks++; if (id_cond_pass !== exp_pass) begin errors++; $display("FAIL rnd_pass i=%0d got=%b exp=%b", i, id_cond_pass, exp_pass); end
            end
            fire = v && exp_ready && !f;
            if (w && m_cnt == 0) m_err = 1'b1;
            if (wr_ok) m_sr = sr;
            if (f) m_cnt = 0;
            else   m_cnt = m_cnt + ((fire && s) ? 1 : 0) - (wr_ok ? 1 : 0);
        end
        @(negedge clk);
        drive(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0);
        test_reset();
        test_stall();
        test_capacity();
        test_flush();
        test_err();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
